tt_um_micro_gfg_development_cic_tx: RTL
=======================================

# tt_um_micro_gfg_development_cic_tx

CIC interpolator and first-order sigma-delta modulator. It is the transmit-side counterpart of the micro-tile CIC decimator. The block takes 4-bit signed samples at the low rate (clk/INTERP), interpolates them by INTERP through a STAGES-stage CIC, and produces a 1-bit PDM stream at clk rate. It sits directly on the micro-tile pins and drives a PDM DAC/speaker path, or loops back into the decimator.

## Interface
- STAGES, 2: number of comb and integrator stages; legal range 1..3.
- INTERP, 4: interpolation ratio; must be a power of two, 2..16. CTR_BITS = log2(INTERP).
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ui_in  in  8  [3:0] sample, signed two's complement; [4] sample_valid; [7:5] unused.
- uo_out  out  8  [0] pdm_out; [1] sample_req; [2] underrun (sticky); [7:3] debug bus.

## Operation
- Phase counter ctr (CTR_BITS wide):
  - Increments every cycle and wraps from INTERP-1 to 0.
  - sample_req = (ctr == INTERP-1), decoded from the ctr register. It is high for exactly one cycle in every INTERP cycles.
- Capture edge: the rising edge at which ctr == INTERP-1.
  - If sample_valid = 1, x <= ui_in[3:0].
  - Else x keeps its last accepted value and underrun <= 1.
  - underrun clears only on reset.
- Comb section (clock-enabled on the capture edge only):
  - c0 = x_new - d0, ck = c(k-1) - dk, with delay registers dk updated to their stage inputs.
  - comb_reg <= c(STAGES-1).
- Zero-stuffing: integrator input = comb_reg when ctr == 0, else 0.
- Integrator section (every cycle):
  - Chained: out_i = in_i + b_i, b_i <= out_i.
  - int_out = b(STAGES-1), the registered last stage.
- Arithmetic:
  - All CIC registers are W = 4 + (STAGES-1)*CTR_BITS bits, two's complement, modular wrap with no saturation.
  - DC gain is INTERP^(STAGES-1), so W holds the full range exactly.
- Modulator:
  - u = int_out + 2^(W-1), i.e. offset-binary, range 0..2^W-1.
  - {carry, acc} <= acc + u, with acc W bits unsigned.
  - pdm_out <= carry (registered).
  - Ones density equals u / 2^W.

## Timing
- Reset values:
  - ctr, x, all comb and integrator registers, comb_reg, acc, pdm_out, underrun and debug are all 0.
  - sample_req is 0 during and after reset until ctr reaches INTERP-1.
- After reset release, the first sample_req is high in the cycle following the (INTERP-1)th rising edge.
- Latency:
  - A sample captured at edge E0 enters the integrators at E1.
  - It first affects pdm_out at E2.
- Reset mid-operation clears everything immediately. No partial sample survives. Counting restarts from 0.
- sample_valid is only examined at the capture edge. Values at other cycles are ignored.
- Simultaneous underrun and reset: reset wins.

## Configuration
- CIC_TX_DEBUG_EN defined: uo_out[7:3] = int_out[W-1 -: 5], the top five bits of int_out, registered in the same cycle as int_out.
- CIC_TX_DEBUG_EN undefined: uo_out[7:3] is tied to 0 and the debug logic is not synthesised.
- pdm_out, sample_req and underrun behave identically in both configurations.

## Structure
- Shared package micro_cic_pkg, used by both this block and the decimator:
  - clog2 function
  - PDM sample width constant (4)
  - register-width function W(STAGES, INTERP)
- One sub-module: micro_cic_sdm, the first-order modulator.
  - Inputs: clk, rst_n, W-bit signed int_out.
  - Output: registered pdm_out.
- CIC comb/integrator chains are generate loops inside the top module.

## Test plan
All scenarios use the defaults STAGES=2, INTERP=4, W=6.
- Reset: hold rst_n = 0 mid-stream with random inputs -> uo_out == 8'h00 immediately; after release, sample_req first goes high in cycle 4, then every 4th cycle.
- Zero input with valid always 1 -> pdm_out settles to the pattern 0,1,0,1… (u=32); underrun stays 0.
- Step 0 -> 4 -> int_out sequence 4, 8, 12, 16 over the next four cycles, then holds at 16. First pdm change occurs 2 cycles after the capture edge.
- Full scale: constant 7 -> int_out = 28, u = 60, and exactly 60 ones in any 64-cycle window after settling. Constant -8 -> int_out = -32 and pdm_out stays 0.
- Underrun: drop sample_valid for one capture edge while the input is 3 -> x holds its previous value, underrun rises after that edge and stays 1 until rst_n goes low.
- Debug config: with CIC_TX_DEBUG_EN, constant 7 -> uo_out[7:3] = 5'b01110; without it -> uo_out[7:3] = 0 and bits [2:0] match the default build cycle-for-cycle.

Source files
------------

// File: rtl/micro_cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | micro_cic_pkg : helpers shared by the micro-tile CIC decimator and TX path  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package micro_cic_pkg;

  localparam int PDM_SAMPLE_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bit growth of a CIC with DC gain INTERP^(STAGES-1) on a 4-bit sample.
  function automatic int cic_width(input int stages, input int interp);
    return PDM_SAMPLE_W + (stages - 1) * clog2(interp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/micro_cic_sdm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | micro_cic_sdm : first-order sigma-delta modulator, W-bit signed in, PDM out |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module micro_cic_sdm #(
  parameter int W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] int_out,
  output logic                pdm_out
);

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] u;
  logic [W:0]   sum;
  logic         pdm_q, pdm_d;

  always_comb begin
    // Adding 2^(W-1) modulo 2^W is an MSB flip: signed -> offset binary.
    u     = {~int_out[W-1], int_out[W-2:0]};
    sum   = {1'b0, acc_q} + {1'b0, u};
    acc_d = sum[W-1:0];
    pdm_d = sum[W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule
`default_nettype wire

// File: rtl/tt_um_micro_gfg_development_cic_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_um_micro_gfg_development_cic_tx : CIC interpolator + sigma-delta PDM TX  |
// | Optional debug bus on uo_out[7:3] when CIC_TX_DEBUG_EN is defined.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tt_um_micro_gfg_development_cic_tx
  import micro_cic_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int INTERP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam int CTR_BITS = clog2(INTERP);
  localparam int W        = cic_width(STAGES, INTERP);
  localparam logic [CTR_BITS-1:0] CTR_LAST = CTR_BITS'(INTERP - 1);

  logic [CTR_BITS-1:0]     ctr_q, ctr_d;
  logic [PDM_SAMPLE_W-1:0] x_q, x_d;
  logic                    underrun_q, underrun_d;
  logic [W-1:0]            comb_reg_q, comb_reg_d;
  logic [W-1:0]            x_ext;
  logic [W-1:0]            int_feed;
  logic [W-1:0]            int_next;
  logic signed [W-1:0]     int_out;
  logic                    capture;
  logic                    sample_valid;
  logic                    pdm_out;
  logic [4:0]              debug;
  logic                    unused_ok;

  assign sample_valid = ui_in[4];
  assign capture      = (ctr_q == CTR_LAST);

  always_comb begin
    ctr_d      = capture ? '0 : ctr_q + CTR_BITS'(1);
    x_d        = x_q;
    underrun_d = underrun_q;
    if (capture) begin
      if (sample_valid) x_d = ui_in[3:0];
      else              underrun_d = 1'b1;
    end
    x_ext = W'($signed(x_d));
  end

  // Comb chain runs only at the low rate; x_ext is the sample accepted this edge.
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic [W-1:0] stage_in, diff, dly_q, dly_d;
    if (k == 0) begin : g_first
      assign stage_in = x_ext;
    end else begin : g_next
      assign stage_in = g_comb[k-1].diff;
    end
    always_comb begin
      diff  = stage_in - dly_q;
      dly_d = capture ? stage_in : dly_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly_q <= '0;
      else        dly_q <= dly_d;
    end
  end

  always_comb begin
    comb_reg_d = capture ? g_comb[STAGES-1].diff : comb_reg_q;
    int_feed   = (ctr_q == '0) ? comb_reg_q : '0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_int
    logic [W-1:0] stage_in, sum, acc_q, acc_d;
    if (k == 0) begin : g_first
      assign stage_in = int_feed;
    end else begin : g_next
      assign stage_in = g_int[k-1].sum;
    end
    always_comb begin
      sum   = stage_in + acc_q;
      acc_d = sum;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
    end
  end

  assign int_next = g_int[STAGES-1].sum;
  assign int_out  = g_int[STAGES-1].acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q      <= '0;
      x_q        <= '0;
      underrun_q <= 1'b0;
      comb_reg_q <= '0;
    end else begin
      ctr_q      <= ctr_d;
      x_q        <= x_d;
      underrun_q <= underrun_d;
      comb_reg_q <= comb_reg_d;
    end
  end

  micro_cic_sdm #(
    .W(W)
  ) u_sdm (
    .clk    (clk),
    .rst_n  (rst_n),
    .int_out(int_out),
    .pdm_out(pdm_out)
  );

`ifdef CIC_TX_DEBUG_EN
  logic [4:0]   debug_q, debug_d;
  logic [W+4:0] debug_ext;

  // Zero padding keeps the top-five slice legal even when W < 5.
  always_comb begin
    debug_ext = {int_next, 5'b00000};
    debug_d   = debug_ext[W+4 -: 5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) debug_q <= '0;
    else        debug_q <= debug_d;
  end

  assign debug     = debug_q;
  assign unused_ok = &{1'b0, ui_in[7:5]};
`else
  assign debug     = 5'd0;
  assign unused_ok = &{1'b0, ui_in[7:5], int_next};
`endif

  assign uo_out = {debug, underrun_q, capture, pdm_out};

endmodule
`default_nettype wire
